// File: rtl/cpu_if_stage_pkg.sv
// Shared constants and the F1 / IF/ID update selector for the instruction-fetch stage.
package cpu_if_stage_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSN     = 32'h0000_0013;

  typedef enum logic [1:0] {
    SLOT_HOLD  = 2'd0,
    SLOT_LOAD  = 2'd1,
    SLOT_FLUSH = 2'd2
  } slot_op_e;

  // Flush wins over stall for every pipeline register in the stage.
  function automatic slot_op_e slot_op(input logic flush, input logic stall);
    if (flush)       return SLOT_FLUSH;
    else if (!stall) return SLOT_LOAD;
    else             return SLOT_HOLD;
  endfunction

endpackage

// File: rtl/if_pc_gen.sv
// PC register, redirect target selection and instruction-memory request issue.
module if_pc_gen
  import cpu_if_stage_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_stall,
  input  logic            jp_taken,
  input  logic [XLEN-1:0] jp_target,
  input  logic            rob_commit_br_taken,
  input  logic [XLEN-1:0] rob_commit_br_target,
  output logic            issue,
  output logic            redirect,
  output logic [XLEN-1:0] target,
  output logic            imem_rd_en,
  output logic [XLEN-1:0] imem_addr
);

  logic [XLEN-1:0] pc_q;

  // The committed branch is older than the decoder jump, so it takes priority.
  always_comb begin
    redirect   = rob_commit_br_taken | jp_taken;
    target     = rob_commit_br_taken ? rob_commit_br_target : jp_target;
    issue      = !rst && !pc_stall;
    imem_rd_en = issue;
    imem_addr  = redirect ? target : pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (issue) begin
      pc_q <= imem_addr + XLEN'(4);
    end else if (redirect) begin
      pc_q <= target;
    end
  end

endmodule

// File: rtl/cpu_if_stage.sv
// Instruction-fetch stage: PC generation, F1 response slot and IF/ID pipeline register.
module cpu_if_stage
  import cpu_if_stage_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_stall,
  input  logic            if_stall,
  input  logic            if_flush,
  input  logic            jp_taken,
  input  logic [XLEN-1:0] jp_target,
  input  logic            rob_commit_br_taken,
  input  logic [XLEN-1:0] rob_commit_br_target,
  output logic            imem_rd_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rd_data,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_insn,
  output logic            if_valid
);

  logic            issue;
  logic            redirect;
  logic [XLEN-1:0] target;

  logic            f1_valid;
  logic [XLEN-1:0] f1_pc;
  logic            f1_fresh;
  logic [XLEN-1:0] f1_buf;
  logic [XLEN-1:0] f1_insn;
  slot_op_e        op;

  if_pc_gen #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk                  (clk),
    .rst                  (rst),
    .pc_stall             (pc_stall),
    .jp_taken             (jp_taken),
    .jp_target            (jp_target),
    .rob_commit_br_taken  (rob_commit_br_taken),
    .rob_commit_br_target (rob_commit_br_target),
    .issue                (issue),
    .redirect             (redirect),
    .target               (target),
    .imem_rd_en           (imem_rd_en),
    .imem_addr            (imem_addr)
  );

  // Memory data is only valid the cycle after the request; longer stalls read the buffered copy.
  always_comb begin
    op      = slot_op(if_flush, if_stall);
    f1_insn = f1_fresh ? imem_rd_data : f1_buf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f1_valid <= 1'b0;
      f1_pc    <= '0;
      f1_fresh <= 1'b0;
      f1_buf   <= XLEN'(NOP_INSN);
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_insn  <= XLEN'(NOP_INSN);
    end else begin
      if (f1_fresh) begin
        f1_buf <= imem_rd_data;
      end
      unique case (op)
        SLOT_FLUSH: begin
          f1_valid <= issue & redirect;
          f1_pc    <= target;
          f1_fresh <= issue & redirect;
          if_valid <= 1'b0;
        end
        SLOT_LOAD: begin
          f1_valid <= issue;
          f1_pc    <= imem_addr;
          f1_fresh <= issue;
          if_valid <= f1_valid;
          if_pc    <= f1_pc;
          if_insn  <= f1_insn;
        end
        default: begin
          f1_fresh <= 1'b0;
        end
      endcase
    end
  end

endmodule
